// File: rtl/lane_arrival_monitor_if.sv
// Bundle of arm/target/lane inputs and capture results for lane_arrival_monitor.
interface lane_arrival_monitor_if #(
  parameter int unsigned NUM_LANES = 6,
  parameter int unsigned LANE_W    = 2,
  parameter int unsigned TS_W      = 8
);
  logic                          start;
  logic                          clear;
  logic [LANE_W-1:0]             target;
  logic [NUM_LANES*LANE_W-1:0]   lanes;
  logic                          busy;
  logic                          done;
  logic                          timeout;
  logic [NUM_LANES-1:0]          arrived;
  logic [NUM_LANES*TS_W-1:0]     stamps;
  logic [3:0]                    first_lane;
  logic [TS_W-1:0]               skew;

  modport master (
    output start, clear, target, lanes,
    input  busy, done, timeout, arrived, stamps, first_lane, skew
  );

  modport slave (
    input  start, clear, target, lanes,
    output busy, done, timeout, arrived, stamps, first_lane, skew
  );
endinterface

// File: rtl/lane_arrival_monitor.sv
// Timestamps the first cycle each lane equals a latched target after an arm
// pulse; reports completion/timeout, arrival mask, stamps, first lane and skew.
module lane_arrival_monitor #(
  parameter int unsigned NUM_LANES = 6,
  parameter int unsigned LANE_W    = 2,
  parameter int unsigned TS_W      = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic                   clk,
  input logic                   rst,
  lane_arrival_monitor_if.slave bus
);

  localparam int unsigned STAMPS_W = NUM_LANES * TS_W;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [LANE_W-1:0]     target_q, target_d;
  logic [TS_W-1:0]       cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_LANES-1:0]  arrived_q, arrived_d;
  logic [STAMPS_W-1:0]   stamps_q, stamps_d;
  logic [3:0]            first_q, first_d;
  logic [TS_W-1:0]       skew_q, skew_d;

  logic [NUM_LANES-1:0]  arr_next_c;
  logic [STAMPS_W-1:0]   stamps_next_c;
  logic                  found_c;
  logic [TS_W-1:0]       min_ts_c, max_ts_c;
  logic [3:0]            first_c;
  logic [TS_W-1:0]       skew_c;

  // This cycle's capture: first match per lane takes the current count.
  always_comb begin
    arr_next_c    = arrived_q;
    stamps_next_c = stamps_q;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (!arrived_q[i] && (bus.lanes[i*LANE_W +: LANE_W] == target_q)) begin
        arr_next_c[i]                  = 1'b1;
        stamps_next_c[i*TS_W +: TS_W]  = cnt_q;
      end
    end
  end

  // Earliest lane (lowest index on ties) and first-to-last spread.
  always_comb begin
    found_c  = 1'b0;
    min_ts_c = '0;
    max_ts_c = '0;
    first_c  = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (arr_next_c[i]) begin
        if (!found_c || (stamps_next_c[i*TS_W +: TS_W] < min_ts_c)) begin
          min_ts_c = stamps_next_c[i*TS_W +: TS_W];
          first_c  = 4'(i);
        end
        if (!found_c || (stamps_next_c[i*TS_W +: TS_W] > max_ts_c)) begin
          max_ts_c = stamps_next_c[i*TS_W +: TS_W];
        end
        found_c = 1'b1;
      end
    end
    skew_c = max_ts_c - min_ts_c;
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    arrived_d = arrived_q;
    stamps_d  = stamps_q;
    first_d   = first_q;
    skew_d    = skew_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_ARMED;
          target_d  = bus.target;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          arrived_d = '0;
          stamps_d  = '0;
          first_d   = '0;
          skew_d    = '0;
        end
      end
      S_ARMED: begin
        arrived_d = arr_next_c;
        stamps_d  = stamps_next_c;
        cnt_d     = cnt_q + TS_W'(1);
        // Completion on the final counted cycle takes precedence over timeout.
        if ((&arr_next_c) || (cnt_q == TS_W'(TIMEOUT - 1))) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = ~(&arr_next_c);
          first_d   = first_c;
          skew_d    = skew_c;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.clear) begin
      state_d   = S_IDLE;
      target_d  = '0;
      cnt_d     = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      arrived_d = '0;
      stamps_d  = '0;
      first_d   = '0;
      skew_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      arrived_q <= '0;
      stamps_q  <= '0;
      first_q   <= '0;
      skew_q    <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      arrived_q <= arrived_d;
      stamps_q  <= stamps_d;
      first_q   <= first_d;
      skew_q    <= skew_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.arrived    = arrived_q;
  assign bus.stamps     = stamps_q;
  assign bus.first_lane = first_q;
  assign bus.skew       = skew_q;

endmodule
